rr_grant_arbiter: RTL
=====================

// Module: rr_grant_arbiter
// PURPOSE
//  Registered N-way round-robin/fixed-priority arbiter.
//  Shares one downstream resource (AXI address/data channel mux, interconnect port) among PORTS requesters.
//  Selection uses two priority_encoder instances: masked requests and raw requests.
//  Grant is held per the chosen blocking mode; pointer rotation gives fairness.
// PARAMETERS
//  PORTS              4  number of requesters (>=1)
//  ARB_TYPE_ROUND_ROBIN 1  1: rotate priority past last winner; 0: fixed priority
//  ARB_BLOCK          1  1: hold grant while winner's request stays high; 0: re-arbitrate every cycle
//  ARB_BLOCK_ACK      1  1 (needs ARB_BLOCK=1): hold grant until winner's acknowledge pulse
//  ARB_LSB_HIGH_PRIORITY 0  1: bit 0 wins ties; 0: bit PORTS-1 wins ties
//  TIMEOUT            256  max cycles one grant may be held (ARB_GRANT_TIMEOUT_EN only)
// PORTS
//  clk            in   1               clock, all logic on rising edge
//  rst            in   1               synchronous reset, active-high
//  request        in   PORTS           per-requester request level
//  acknowledge    in   PORTS           per-requester release pulse (used when ARB_BLOCK_ACK=1)
//  grant          out  PORTS           one-hot registered grant
//  grant_valid    out  1               any grant active
//  grant_encoded  out  $clog2(PORTS)   binary index of granted port (width 1 when PORTS=1)
//  timeout        out  1               one-cycle pulse on forced release (0 without macro)
// BEHAVIOUR
//  Reset: grant=0, grant_valid=0, grant_encoded=0, mask=0, timeout=0, hold counter=0.
//  Latency: request at cycle N -> grant at N+1 (all outputs registered); no combinational in->out path.
//  States: IDLE (grant_valid=0) / GRANTED (grant_valid=1).
//  Release condition while GRANTED:
//   ARB_BLOCK_ACK=1: acknowledge[grant_encoded] high.
//   ARB_BLOCK=1, ACK=0: request[grant_encoded] low.
//   ARB_BLOCK=0: every cycle.
//  Acknowledge on a non-granted bit is ignored.
//  On release, or in IDLE, next grant = masked-encoder winner if any masked request, else raw-encoder winner, else IDLE.
//  Release and re-grant may happen in the same cycle: no idle bubble.
//  The released port competes the same cycle at lowest RR priority.
//  Mask (ARB_TYPE_ROUND_ROBIN=1), updated on each new grant to index k:
//   ARB_LSB_HIGH_PRIORITY=0: bits below k set.
//   ARB_LSB_HIGH_PRIORITY=1: bits above k set.
//   The granted port therefore ranks last next time.
//  Fixed priority: mask forced all-ones (raw encoder only).
//  Single requester: it may be re-granted back-to-back indefinitely.
//  Requests arriving during a hold are not lost: levels are sampled at release.
//  rst mid-grant: the next cycle returns all state to reset values.
//  Invariants: grant one-hot or zero; grant_valid == |grant; grant_encoded matches grant.
// CONFIGURATION
//  Macro ARB_GRANT_TIMEOUT_EN defined:
//   Hold counter increments each GRANTED cycle.
//   Reaching TIMEOUT-1 forces release, pulses timeout for 1 cycle and re-arbitrates.
//   The timed-out port gets lowest RR priority.
//   Counter clears on any release.
//  Macro undefined: no counter, timeout tied 0, grant held indefinitely per the blocking mode.
// STRUCTURE
//  Shared package arb_pkg: ARB_MODE constants (FIXED/RR), blocking-mode encodings, clog2 width helper.
//  Sub-module: priority_encoder, 2 instances (masked, unmasked), same LSB_HIGH_PRIORITY.
//  This block contains only the registers, mask logic and hold/timeout control.
// TESTING
//  1. PORTS=4, RR, BLOCK_ACK:
//     request=4'b1111 held, ack each grant next cycle.
//     Expect grant order 3,2,1,0,3.
//  2. Same config, request=4'b0101:
//     Expect grant alternates 2,0,2; grant never 4'b0010 or 4'b1000.
//  3. Fixed priority, ARB_BLOCK=0, request=4'b0011 then 4'b1011:
//     Expect grant 4'b0010, then 4'b1000 one cycle after the change.
//  4. BLOCK_ACK, port 1 granted, acknowledge=4'b0100 (wrong port):
//     Expect grant stays 4'b0010 until acknowledge[1]=1.
//  5. rst asserted 1 cycle while grant=4'b0100:
//     Expect grant=0, grant_valid=0 next cycle; with request=4'b1111 after reset, first grant=3.
//  6. ARB_GRANT_TIMEOUT_EN, TIMEOUT=8, port 0 never acks, request=4'b0011:
//     Expect timeout pulse 8 cycles after grant, then grant=4'b0010 the same edge.

Source files
------------

// File: rtl/rr_grant_arbiter_pkg.sv
// Shared arbiter definitions: arbitration mode constants, blocking-mode and
// state encodings, and an encoded-width helper.
package arb_pkg;

    localparam int unsigned ARB_MODE_FIXED = 0;
    localparam int unsigned ARB_MODE_RR    = 1;

    typedef enum logic [1:0] {
        BLK_NONE,
        BLK_REQUEST,
        BLK_ACK
    } blk_mode_e;

    typedef enum logic {
        ST_IDLE,
        ST_GRANTED
    } arb_state_e;

    // Width of a binary index into n items; never below 1 so PORTS=1 still has a bus.
    function automatic int unsigned clog2_w(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic blk_mode_e blk_mode(input bit block, input bit block_ack);
        if (block && block_ack) begin
            return BLK_ACK;
        end else if (block) begin
            return BLK_REQUEST;
        end
        return BLK_NONE;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_priority_encoder.sv
// Combinational priority encoder: picks one set bit of input_unencoded,
// lowest index first when LSB_HIGH_PRIORITY=1, highest index first otherwise.
module priority_encoder
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH             = 4,
    parameter bit          LSB_HIGH_PRIORITY = 1'b0,
    parameter int unsigned ENC_W             = clog2_w(WIDTH)
) (
    input  logic [WIDTH-1:0] input_unencoded,
    output logic             output_valid,
    output logic [ENC_W-1:0] output_encoded,
    output logic [WIDTH-1:0] output_unencoded
);

    always_comb begin
        output_valid   = 1'b0;
        output_encoded = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (LSB_HIGH_PRIORITY) begin
                if (input_unencoded[WIDTH-1-i]) begin
                    output_valid   = 1'b1;
                    output_encoded = ENC_W'(WIDTH-1-i);
                end
            end else if (input_unencoded[i]) begin
                output_valid   = 1'b1;
                output_encoded = ENC_W'(i);
            end
        end
        output_unencoded = output_valid ? (WIDTH'(1) << output_encoded) : '0;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin / fixed-priority arbiter with selectable grant hold mode.
// Optional forced release after TIMEOUT cycles under macro ARB_GRANT_TIMEOUT_EN.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned PORTS                 = 4,
    parameter bit          ARB_TYPE_ROUND_ROBIN  = 1'b1,
    parameter bit          ARB_BLOCK             = 1'b1,
    parameter bit          ARB_BLOCK_ACK         = 1'b1,
    parameter bit          ARB_LSB_HIGH_PRIORITY = 1'b0,
    parameter int unsigned TIMEOUT               = 256,
    localparam int unsigned ENC_W                = clog2_w(PORTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] request,
    input  logic [PORTS-1:0] acknowledge,
    output logic [PORTS-1:0] grant,
    output logic             grant_valid,
    output logic [ENC_W-1:0] grant_encoded,
    output logic             timeout
);

    localparam blk_mode_e BLK_MODE = blk_mode(ARB_BLOCK, ARB_BLOCK_ACK);

    arb_state_e       state_q, state_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [PORTS-1:0] mask_q, mask_d;
    logic [ENC_W-1:0] enc_q, enc_d;
    logic             timeout_q, timeout_d;

    logic [PORTS-1:0] masked_request;
    logic             m_valid, r_valid;
    logic [ENC_W-1:0] m_enc, r_enc, win_enc;
    logic [PORTS-1:0] m_onehot, r_onehot;
    logic             hold_release, force_release, arbitrate;

    // Fixed priority behaves as a permanently all-ones mask.
    assign masked_request = request & (ARB_TYPE_ROUND_ROBIN ? mask_q : '1);

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY),
        .ENC_W             (ENC_W)
    ) u_enc_masked (
        .input_unencoded  (masked_request),
        .output_valid     (m_valid),
        .output_encoded   (m_enc),
        .output_unencoded (m_onehot)
    );

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY),
        .ENC_W             (ENC_W)
    ) u_enc_raw (
        .input_unencoded  (request),
        .output_valid     (r_valid),
        .output_encoded   (r_enc),
        .output_unencoded (r_onehot)
    );

    always_comb begin
        case (BLK_MODE)
            BLK_ACK:     hold_release = acknowledge[enc_q];
            BLK_REQUEST: hold_release = !request[enc_q];
            default:     hold_release = 1'b1;
        endcase
    end

`ifdef ARB_GRANT_TIMEOUT_EN
    localparam int unsigned CNT_W = clog2_w(TIMEOUT);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    // A natural release in the expiry cycle wins, so timeout only flags forced releases.
    assign force_release = (state_q == ST_GRANTED) && !hold_release &&
                           (hold_cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (arbitrate) begin
            hold_cnt_d = '0;
        end else if (state_q == ST_GRANTED) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign force_release = 1'b0;
`endif

    assign arbitrate = (state_q == ST_IDLE) || hold_release || force_release;
    assign win_enc   = m_valid ? m_enc : r_enc;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        enc_d     = enc_q;
        mask_d    = mask_q;
        timeout_d = force_release;
        if (arbitrate) begin
            if (m_valid || r_valid) begin
                state_d = ST_GRANTED;
                grant_d = m_valid ? m_onehot : r_onehot;
                enc_d   = win_enc;
                for (int unsigned i = 0; i < PORTS; i++) begin
                    mask_d[i] = ARB_LSB_HIGH_PRIORITY ? (ENC_W'(i) > win_enc)
                                                      : (ENC_W'(i) < win_enc);
                end
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
                enc_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            enc_q     <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            enc_q     <= enc_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant         = grant_q;
    assign grant_valid   = (state_q == ST_GRANTED);
    assign grant_encoded = enc_q;
    assign timeout       = timeout_q;

endmodule
